wb_unit: RTL
============

Name: wb_unit

Overview:
Writeback stage that drives the register-file write port and its bypass inputs. It merges an always-streaming ALU result path with a bursty load-data path. Load data is formatted (sign/zero extension, byte/half select) and held in a small FIFO. The block then issues at most one register write per cycle. That write is registered and also presented as the bypass pair so same-cycle readers see it.

Parameters:
XLEN, 32, datapath width (matches the define.v XLEN).
DEPTH, 2, load FIFO entries; power of 2, at least 2.
STARVE_MAX, 4, cycles a waiting load head may be blocked by ALU traffic before forcing priority; at least 1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle when high together with alu_valid
alu_rd  input  5  ALU destination register
alu_res  input  XLEN  ALU result
ld_valid  input  1  load data offered
ld_ready  output  1  load FIFO can accept
ld_rd  input  5  load destination register
ld_data  input  XLEN  raw aligned memory word
ld_funct3  input  3  load type: LB/LH/LW/LBU/LHU
ld_off  input  2  byte offset of the access
ld_count  output  clog2(DEPTH)+1  FIFO occupancy
rf_we  output  1  register write enable
rf_rd  output  5  register write address
rf_wdata  output  XLEN  register write data
bypass_rd  output  5  bypass address
bypass_res  output  XLEN  bypass data

Behaviour:
- Reset (asynchronous, rst_n=0): rf_we=0, rf_rd=0, rf_wdata=0, bypass_rd=0, bypass_res=0, FIFO emptied, ld_count=0, starve counter=0. Entries held at reset are discarded.
- Formatting happens at enqueue; the FIFO stores the final XLEN value.
  - LB (000): sign-extend byte ld_off.
  - LH (001): sign-extend half ld_off[1].
  - LW (010): word unchanged.
  - LBU (100): zero-extend byte ld_off.
  - LHU (101): zero-extend half ld_off[1].
  - Any other funct3: treated as LW.
- ld_ready = !full, from registered state only. There is no pass-through when full, even if a dequeue happens in the same cycle.
- Enqueue occurs when ld_valid && ld_ready. Simultaneous enqueue and dequeue leaves ld_count unchanged. Pointers wrap modulo DEPTH.
- Arbitration, evaluated each cycle:
  - alu_ready = !(FIFO non-empty && starve == STARVE_MAX).
  - If alu_valid && alu_ready, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and dequeued.
  - Otherwise nothing is selected.
- Starve counter:
  - Increments while the FIFO is non-empty and the head is not dequeued.
  - Clears on dequeue or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Output register (latency 1): a result selected in cycle N appears on rf_we/rf_rd/rf_wdata at edge N+1.
  - bypass_rd and bypass_res mirror rf_rd and rf_wdata exactly.
- No write, or selected rd==0: the result is consumed but rf_we=0, rf_rd=0, rf_wdata=0, bypass_rd=0, bypass_res=0. This keeps x0 bypass reads at 0.
- Ordering:
  - ALU results are written in acceptance order.
  - Loads are written in FIFO order.
  - No ordering is enforced between the two paths. When both paths target the same rd, the later write wins.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_res=0xDEADBEEF at cycle N -> at N+1 rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, bypass_rd=5, bypass_res=0xDEADBEEF; alu_ready stays 1.
- x0 suppression: ALU rd=0, res=0x12345678 -> next cycle rf_we=0, bypass_rd=0, bypass_res=0.
- Load formatting, ALU idle:
  - LB, off=2, data=0x00800000 -> rf_wdata=0xFFFFFF80.
  - LBU, same inputs -> 0x00000080.
  - LH, off=2, data=0x80010000 -> 0xFFFF8001.
  - LHU, same inputs -> 0x00008001.
  - funct3=011, data=0x0000ABCD -> 0x0000ABCD.
- Starvation, DEPTH=2, STARVE_MAX=4: continuous alu_valid plus two loads -> ld_count=2 and ld_ready=0. After 4 blocked cycles alu_ready=0 for exactly one cycle and load 1 is written. After 4 more blocked cycles load 2 is written.
- Same rd: ALU rd=7 res=1 and load rd=7 data=2 in the same cycle -> rd 7 written 1 at N+1, then 2 at N+2 (FIFO drains when ALU idle) -> final value 2.
- Reset mid-operation: FIFO holds 1 entry, rst_n driven low mid-cycle -> all outputs 0 and ld_count=0 immediately. After release, no stale write occurs.

Source files
------------

// File: rtl/wb_unit_if.sv
// Writeback bus: ALU result stream, load-data stream, and the register-file
// write/bypass outputs of wb_unit.
interface wb_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [4:0]               alu_rd;
  logic [XLEN-1:0]          alu_res;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [4:0]               ld_rd;
  logic [XLEN-1:0]          ld_data;
  logic [2:0]               ld_funct3;
  logic [1:0]               ld_off;
  logic [$clog2(DEPTH):0]   ld_count;
  logic                     rf_we;
  logic [4:0]               rf_rd;
  logic [XLEN-1:0]          rf_wdata;
  logic [4:0]               bypass_rd;
  logic [XLEN-1:0]          bypass_res;

  modport master (
    output alu_valid, alu_rd, alu_res, ld_valid, ld_rd, ld_data, ld_funct3, ld_off,
    input  alu_ready, ld_ready, ld_count, rf_we, rf_rd, rf_wdata, bypass_rd, bypass_res
  );

  modport slave (
    input  alu_valid, alu_rd, alu_res, ld_valid, ld_rd, ld_data, ld_funct3, ld_off,
    output alu_ready, ld_ready, ld_count, rf_we, rf_rd, rf_wdata, bypass_rd, bypass_res
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: merges the ALU stream with a formatted load FIFO into one
// registered register-file write per cycle, mirrored onto the bypass pair.
module wb_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic    clk,
  input logic    rst_n,
  wb_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [XLEN-1:0] r_mem    [DEPTH];
  logic [4:0]      r_rd_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [SW-1:0]   r_starve;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;

  logic [XLEN-1:0] w_bshift, w_hshift, w_fmt;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_nempty, w_full, w_starved;
  logic            w_sel_alu, w_deq, w_enq, w_we;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [SW-1:0]   w_starve_d;

  // Load formatting is done at enqueue so the FIFO holds final register values.
  always_comb begin
    w_bshift = bus.ld_data >> {bus.ld_off, 3'b000};
    w_hshift = bus.ld_data >> {bus.ld_off[1], 4'b0000};
    w_byte   = w_bshift[7:0];
    w_half   = w_hshift[15:0];
    case (bus.ld_funct3)
      3'b000:  w_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_fmt = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_fmt = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_fmt = {{(XLEN-16){1'b0}}, w_half};
      default: w_fmt = bus.ld_data;
    endcase
  end

  always_comb begin
    w_nempty   = (r_count != '0);
    w_full     = (r_count == (AW+1)'(DEPTH));
    w_starved  = w_nempty && (r_starve == SW'(STARVE_MAX));
    w_sel_alu  = bus.alu_valid && !w_starved;
    w_deq      = !w_sel_alu && w_nempty;
    w_enq      = bus.ld_valid && !w_full;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (w_sel_alu) begin
      w_sel_rd   = bus.alu_rd;
      w_sel_data = bus.alu_res;
    end else if (w_deq) begin
      w_sel_rd   = r_rd_mem[r_rptr];
      w_sel_data = r_mem[r_rptr];
    end
    // rd==0 is consumed silently so x0 bypass reads stay zero.
    w_we = (w_sel_alu || w_deq) && (w_sel_rd != 5'd0);
    if (!w_nempty || w_deq) begin
      w_starve_d = '0;
    end else if (r_starve == SW'(STARVE_MAX)) begin
      w_starve_d = r_starve;
    end else begin
      w_starve_d = r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr]    <= w_fmt;
      r_rd_mem[r_wptr] <= bus.ld_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_starve <= w_starve_d;
      r_we     <= w_we;
      r_rd     <= w_we ? w_sel_rd : 5'd0;
      r_wdata  <= w_we ? w_sel_data : '0;
    end
  end

  assign bus.alu_ready  = !w_starved;
  assign bus.ld_ready   = !w_full;
  assign bus.ld_count   = r_count;
  assign bus.rf_we      = r_we;
  assign bus.rf_rd      = r_rd;
  assign bus.rf_wdata   = r_wdata;
  assign bus.bypass_rd  = r_rd;
  assign bus.bypass_res = r_wdata;
endmodule
